// File: rtl/pc_gen.sv
// Fetch-stage program counter: holds the registered fetch PC, offers it over
// a valid/ready handshake and redirects on resolved control flow or returns.
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            cf_valid,
    input  logic [1:0]      cf_type,
    input  logic            cf_push,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] jump_addr,
    input  logic [XLEN-1:0] read_data,
    input  logic            if_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_link,
    output logic            trap_taken,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam int              PW           = $clog2(RAS_DEPTH);
    localparam logic [PW:0]     RAS_FULL_CNT = (PW+1)'(RAS_DEPTH);
    localparam logic [PW:0]     CNT_ONE      = (PW+1)'(1);
    localparam logic [PW-1:0]   PTR_ONE      = PW'(1);
    localparam logic [XLEN-1:0] INSN_BYTES   = XLEN'(4);

    typedef enum logic {S_BOOT, S_RUN} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              trap_q, trap_d;
    logic [PW-1:0]     ras_ptr_q, ras_ptr_d;
    logic [PW:0]       ras_cnt_q, ras_cnt_d;
    logic [XLEN-1:0]   ras_mem_q [RAS_DEPTH];

    logic              ras_we;
    logic [PW-1:0]     ras_waddr;
    logic [XLEN-1:0]   ras_wdata;

    logic              redirect;
    logic              do_push;
    logic              do_pop;
    logic              ras_hit;
    logic [XLEN-1:0]   link;
    logic [XLEN-1:0]   indirect;
    logic [XLEN-1:0]   target;

    function automatic logic [XLEN-1:0] clear_lsb(input logic [XLEN-1:0] a);
        return {a[XLEN-1:1], 1'b0};
    endfunction

    assign link     = pc_in + INSN_BYTES;
    assign indirect = clear_lsb(read_data + jump_addr);
    assign redirect = cf_valid && (cf_type != 2'b00);
    assign do_push  = cf_valid && cf_push;
    assign do_pop   = cf_valid && (cf_type == 2'b11);
    assign ras_hit  = (ras_cnt_q != '0);

    // Target select: an empty return stack falls back to the indirect target.
    always_comb begin
        target = '0;
        case (cf_type)
            2'b01:   target = pc_in + jump_addr;
            2'b10:   target = indirect;
            2'b11:   target = ras_hit ? ras_mem_q[ras_ptr_q] : indirect;
            default: target = '0;
        endcase
    end

    always_comb begin
        state_d = S_RUN;
        pc_d    = pc_q;
        trap_d  = 1'b0;
        if (redirect) begin
            if (target[1:0] != 2'b00) begin
                pc_d   = TRAP_VEC;
                trap_d = 1'b1;
            end else begin
                pc_d = target;
            end
        end else if ((state_q == S_RUN) && !stall && if_ready) begin
            pc_d = pc_q + INSN_BYTES;
        end
    end

    // Push+pop swaps the top in place; a push when full overwrites the oldest slot.
    always_comb begin
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        ras_we    = 1'b0;
        ras_waddr = ras_ptr_q;
        ras_wdata = link;
        if (do_push && do_pop) begin
            ras_we = 1'b1;
            if (!ras_hit) begin
                ras_cnt_d = CNT_ONE;
            end
        end else if (do_push) begin
            ras_ptr_d = ras_ptr_q + PTR_ONE;
            ras_waddr = ras_ptr_q + PTR_ONE;
            ras_we    = 1'b1;
            if (ras_cnt_q != RAS_FULL_CNT) begin
                ras_cnt_d = ras_cnt_q + CNT_ONE;
            end
        end else if (do_pop && ras_hit) begin
            ras_ptr_d = ras_ptr_q - PTR_ONE;
            ras_cnt_d = ras_cnt_q - CNT_ONE;
        end
    end

    // Register stage: control and PC state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_VEC;
            trap_q    <= 1'b0;
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            trap_q    <= trap_d;
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    // Stack storage is unreachable until a push, so it carries no reset.
    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_mem_q[ras_waddr] <= ras_wdata;
        end
    end

    assign if_valid   = (state_q == S_RUN);
    assign pc_out     = pc_q;
    assign pc_link    = link;
    assign trap_taken = trap_q;
    assign ras_empty  = !ras_hit;
    assign ras_full   = (ras_cnt_q == RAS_FULL_CNT);

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed steps queue the outputs expected after
// each clock edge, and a monitor compares them one edge later.
module tb_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        cf_valid;
    logic [1:0]  cf_type;
    logic        cf_push;
    logic [31:0] pc_in;
    logic [31:0] jump_addr;
    logic [31:0] read_data;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_link;
    logic        trap_taken;
    logic        ras_empty;
    logic        ras_full;

    pc_gen #(
        .XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .cf_valid(cf_valid),
        .cf_type(cf_type), .cf_push(cf_push), .pc_in(pc_in),
        .jump_addr(jump_addr), .read_data(read_data), .if_ready(if_ready),
        .if_valid(if_valid), .pc_out(pc_out), .pc_link(pc_link),
        .trap_taken(trap_taken), .ras_empty(ras_empty), .ras_full(ras_full)
    );

    typedef struct {
        logic        vld;
        logic [31:0] pc;
        logic        trap;
        logic        empty;
        logic        full;
        logic [31:0] link;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] ret_pc[4] = '{32'h54, 32'h44, 32'h34, 32'h24};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        stall = 0; cf_valid = 0; cf_type = 2'b00; cf_push = 0;
        pc_in = 0; jump_addr = 0; read_data = 0; if_ready = 0;
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic st, input logic cfv, input logic [1:0] ty, input logic psh,
                        input logic [31:0] pi, input logic [31:0] ja, input logic [31:0] rd,
                        input logic rdy, input logic [31:0] epc, input logic etrap,
                        input logic eemp, input logic efull);
        exp_t e;
        stall = st; cf_valid = cfv; cf_type = ty; cf_push = psh;
        pc_in = pi; jump_addr = ja; read_data = rd; if_ready = rdy;
        e.vld = 1'b1; e.pc = epc; e.trap = etrap; e.empty = eemp; e.full = efull;
        e.link = pi + 32'd4;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"}, pc_out, 32'h0);
        chk({tag, "_vld"}, {31'b0, if_valid}, 32'h0);
        chk({tag, "_trap"}, {31'b0, trap_taken}, 32'h0);
        chk({tag, "_empty"}, {31'b0, ras_empty}, 32'h1);
        chk({tag, "_full"}, {31'b0, ras_full}, 32'h0);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expected outputs never compared, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("pc_out", pc_out, e.pc);
                chk("if_valid", {31'b0, if_valid}, {31'b0, e.vld});
                chk("trap_taken", {31'b0, trap_taken}, {31'b0, e.trap});
                chk("ras_empty", {31'b0, ras_empty}, {31'b0, e.empty});
                chk("ras_full", {31'b0, ras_full}, {31'b0, e.full});
                chk("pc_link", pc_link, e.link);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        #1;
        chk("boot_vld", {31'b0, if_valid}, 32'h0);
        chk("boot_pc", pc_out, 32'h0);

        // Boot edge, then sequential fetch 4..0x20
        step(0, 0, 2'b00, 0, 0, 0, 0, 1, 32'h0, 0, 1, 0);
        for (int i = 1; i <= 8; i++) step(0, 0, 2'b00, 0, 0, 0, 0, 1, 32'(i * 4), 0, 1, 0);

        // Not ready: request held, then accepted
        repeat (3) step(0, 0, 2'b00, 0, 0, 0, 0, 0, 32'h20, 0, 1, 0);
        step(0, 0, 2'b00, 0, 0, 0, 0, 1, 32'h24, 0, 1, 0);

        // Redirect beats stall, wrapping add; then stall holds
        step(1, 1, 2'b01, 0, 32'h40, 32'hFFFF_FFF0, 0, 1, 32'h30, 0, 1, 0);
        step(1, 0, 2'b00, 0, 0, 0, 0, 1, 32'h30, 0, 1, 0);
        step(0, 0, 2'b00, 0, 0, 0, 0, 1, 32'h34, 0, 1, 0);

        // Indirect with bit0 cleared, redirect while not ready
        step(0, 1, 2'b10, 0, 0, 0, 32'h1001, 0, 32'h1000, 0, 1, 0);

        // Misaligned target traps, pulse lasts one cycle
        step(0, 1, 2'b01, 0, 32'h40, 32'h2, 0, 1, 32'h100, 1, 1, 0);
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 32'h100, 0, 1, 0);

        // Five calls: full after the fourth, fifth overwrites the oldest
        for (int i = 1; i <= 5; i++)
            step(0, 1, 2'b01, 1, 32'(i * 16), 32'h200, 0, 1, 32'(i * 16 + 32'h200), 0, 0, i >= 4);

        // Four returns, then a fallback return on the empty stack
        for (int i = 0; i < 4; i++)
            step(0, 1, 2'b11, 0, 0, 0, 0, 1, ret_pc[i], 0, i == 3, 0);
        step(0, 1, 2'b11, 0, 0, 0, 32'h80, 1, 32'h80, 0, 1, 0);

        // Push+pop: on empty uses fallback and count becomes 1; otherwise swaps top
        step(0, 1, 2'b11, 1, 32'h60, 0, 32'h90, 1, 32'h90, 0, 0, 0);
        step(0, 1, 2'b01, 1, 32'h70, 32'h200, 0, 1, 32'h270, 0, 0, 0);
        step(0, 1, 2'b11, 1, 32'h80, 0, 0, 1, 32'h74, 0, 0, 0);
        step(0, 1, 2'b11, 0, 0, 0, 0, 1, 32'h84, 0, 0, 0);
        step(0, 1, 2'b11, 0, 0, 0, 0, 1, 32'h64, 0, 1, 0);

        // Leave one entry on the stack, then reset mid-operation
        step(0, 1, 2'b01, 1, 32'h10, 32'h200, 0, 0, 32'h210, 0, 0, 0);
        idle();
        drain();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reboot_vld", {31'b0, if_valid}, 32'h0);
        chk("reboot_pc", pc_out, 32'h0);

        // Return during boot: stack was discarded so fallback is taken
        step(0, 1, 2'b11, 0, 0, 0, 32'hC0, 1, 32'hC0, 0, 1, 0);
        step(0, 0, 2'b00, 0, 0, 0, 0, 1, 32'hC4, 0, 1, 0);
        idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
